stage_sequencer: RTL and testbench

//  Parametrised multi-cycle instruction sequencer: FETCH->DECODE->EXEC->[MEM]->WB.

---
 rtl/stage_sequencer.sv | 144 ++++++++++++++
 tb/tb_stage_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle instruction sequencer FETCH->DECODE->EXEC->[MEM]->WB.
// Issues one-cycle start pulses to the fetch, decode, execute, memory and writeback
// units and waits on their finish handshakes. A per-stage timeout drops into a
// sticky FAULT state. Also provides flush/abort, halt at instruction boundary and a
// retire counter.
//
// Ports
//   clk          clock
//   rst          asynchronous active-low reset
//   halt_req     hold in IDLE at an instruction boundary while high
//   flush        abort the current instruction and restart at FETCH via IDLE
//   need_mem     from the decoder, sampled in DECODE (1 = load/store)
//   ifu_finish   fetch done, honoured only in FETCH
//   exu_finish   execute done, honoured only in EXEC
//   memu_finish  memory done, honoured only in MEM
//   ifu_valid    start pulse, fetch
//   idu_valid    start pulse, decode
//   exu_valid    start pulse, execute
//   memu_valid   start pulse, memory
//   wb_valid     start pulse, writeback
//   stage        current state encoding
//   halted       IDLE with halt_req high
//   timeout_err  high while in FAULT
//   retire       high for the single WB cycle
//   retire_cnt   retired instruction count, wraps
module stage_sequencer #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             flush,
  input  logic             need_mem,
  input  logic             ifu_finish,
  input  logic             exu_finish,
  input  logic             memu_finish,
  output logic             ifu_valid,
  output logic             idu_valid,
  output logic             exu_valid,
  output logic             memu_valid,
  output logic             wb_valid,
  output logic [2:0]       stage,
  output logic             halted,
  output logic             timeout_err,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned TO_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd6
  } state_t;

  state_t          state;
  state_t          nxt_state;
  logic [TO_W-1:0] to_cnt;
  logic            mem_flag;
  logic            finish;
  logic            timeout;

  // Finish of the stage currently being waited on; other finishes are ignored.
  always_comb begin
    finish = 1'b0;
    case (state)
      FETCH:   finish = ifu_finish;
      EXEC:    finish = exu_finish;
      MEM:     finish = memu_finish;
      default: finish = 1'b0;
    endcase
  end

  // to_cnt counts from 0 on entry, so the stage gets exactly TIMEOUT cycles;
  // a finish in the last allowed cycle wins.
  assign timeout = (TIMEOUT != 0) && (to_cnt == TO_LAST) && !finish;

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    nxt_state = halt_req ? IDLE : FETCH;
      FETCH: begin
        if (flush)        nxt_state = IDLE;
        else if (finish)  nxt_state = DECODE;
        else if (timeout) nxt_state = FAULT;
        else              nxt_state = FETCH;
      end
      DECODE:  nxt_state = flush ? IDLE : EXEC;
      EXEC: begin
        if (flush)        nxt_state = IDLE;
        else if (finish)  nxt_state = mem_flag ? MEM : WB;
        else if (timeout) nxt_state = FAULT;
        else              nxt_state = EXEC;
      end
      MEM: begin
        if (flush)        nxt_state = IDLE;
        else if (finish)  nxt_state = WB;
        else if (timeout) nxt_state = FAULT;
        else              nxt_state = MEM;
      end
      WB:      nxt_state = (flush || halt_req) ? IDLE : FETCH;
      FAULT:   nxt_state = FAULT;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      to_cnt     <= '0;
      mem_flag   <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= nxt_state;
      if (state != nxt_state)
        to_cnt <= '0;
      else if ((state == FETCH || state == EXEC || state == MEM) && !finish)
        to_cnt <= to_cnt + TO_W'(1);
      if (state == DECODE)
        mem_flag <= need_mem;
      if (state == WB)
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // Start pulses fire combinationally in the cycle before the entering edge.
  assign ifu_valid   = rst && (state != FETCH)  && (nxt_state == FETCH);
  assign idu_valid   = rst && (state != DECODE) && (nxt_state == DECODE);
  assign exu_valid   = rst && (state != EXEC)   && (nxt_state == EXEC);
  assign memu_valid  = rst && (state != MEM)    && (nxt_state == MEM);
  assign wb_valid    = rst && (state != WB)     && (nxt_state == WB);
  assign retire      = rst && (state == WB);
  assign stage       = state;
  assign halted      = (state == IDLE) && halt_req;
  assign timeout_err = (state == FAULT);

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       halt_req, flush, need_mem, ifu_finish, exu_finish, memu_finish;
  logic       ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid;
  logic [2:0] stage;
  logic       halted, timeout_err, retire;
  logic [3:0] retire_cnt;

  int checks   = 0;
  int failures = 0;

  stage_sequencer #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .halt_req    (halt_req),
    .flush       (flush),
    .need_mem    (need_mem),
    .ifu_finish  (ifu_finish),
    .exu_finish  (exu_finish),
    .memu_finish (memu_finish),
    .ifu_valid   (ifu_valid),
    .idu_valid   (idu_valid),
    .exu_valid   (exu_valid),
    .memu_valid  (memu_valid),
    .wb_valid    (wb_valid),
    .stage       (stage),
    .halted      (halted),
    .timeout_err (timeout_err),
    .retire      (retire),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  // in = {halt_req, flush, need_mem, ifu_finish, exu_finish, memu_finish}
  // v  = {ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid}
  typedef struct {
    logic [5:0] in;
    logic [2:0] st;
    logic [4:0] v;
    logic       ret;
    logic       hlt;
    logic       err;
    logic [3:0] cnt;
  } vec_t;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;
  localparam logic [4:0] P_NONE = 5'b00000, P_IFU = 5'b10000, P_IDU = 5'b01000,
                         P_EXU = 5'b00100, P_MEM = 5'b00010, P_WB = 5'b00001;
  localparam logic [5:0] ALL = 6'b000111;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic [5:0] in, input logic [2:0] st, input logic [4:0] v,
                              input logic ret, input logic hlt, input logic err,
                              input logic [3:0] cnt);
    vec_t r;
    r.in = in; r.st = st; r.v = v; r.ret = ret; r.hlt = hlt; r.err = err; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, compare on the falling edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    {halt_req, flush, need_mem, ifu_finish, exu_finish, memu_finish} = v.in;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("row%0d_stage", idx), 16'(stage), 16'(e.st));
    chk($sformatf("row%0d_pulses", idx),
        16'({ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid}), 16'(e.v));
    chk($sformatf("row%0d_retire", idx), 16'(retire), 16'(e.ret));
    chk($sformatf("row%0d_halted", idx), 16'(halted), 16'(e.hlt));
    chk($sformatf("row%0d_timeout_err", idx), 16'(timeout_err), 16'(e.err));
    chk($sformatf("row%0d_retire_cnt", idx), 16'(retire_cnt), 16'(e.cnt));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Back-to-back ALU instructions, all finishes tied high: 4 cycles each.
    tbl.push_back(mk(ALL, S_IDLE, P_IFU, 1'b0, 1'b0, 1'b0, 4'd0));
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk(ALL, S_FETCH, P_IDU, 1'b0, 1'b0, 1'b0, 4'(i)));
      tbl.push_back(mk(ALL, S_DEC,   P_EXU, 1'b0, 1'b0, 1'b0, 4'(i)));
      tbl.push_back(mk(ALL, S_EXEC,  P_WB,  1'b0, 1'b0, 1'b0, 4'(i)));
      tbl.push_back(mk(ALL, S_WB,    P_IFU, 1'b1, 1'b0, 1'b0, 4'(i)));
    end
    // Load/store with memu_finish three cycles late.
    tbl.push_back(mk(6'b001110, S_FETCH, P_IDU,  1'b0, 1'b0, 1'b0, 4'd3));
    tbl.push_back(mk(6'b001110, S_DEC,   P_EXU,  1'b0, 1'b0, 1'b0, 4'd3));
    tbl.push_back(mk(6'b001110, S_EXEC,  P_MEM,  1'b0, 1'b0, 1'b0, 4'd3));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(6'b001000, S_MEM, P_NONE, 1'b0, 1'b0, 1'b0, 4'd3));
    tbl.push_back(mk(6'b001001, S_MEM,   P_WB,   1'b0, 1'b0, 1'b0, 4'd3));
    tbl.push_back(mk(6'b000000, S_WB,    P_IFU,  1'b1, 1'b0, 1'b0, 4'd3));
    // Flush in MEM beats memu_finish: no retire.
    tbl.push_back(mk(6'b001100, S_FETCH, P_IDU,  1'b0, 1'b0, 1'b0, 4'd4));
    tbl.push_back(mk(6'b001000, S_DEC,   P_EXU,  1'b0, 1'b0, 1'b0, 4'd4));
    tbl.push_back(mk(6'b001010, S_EXEC,  P_MEM,  1'b0, 1'b0, 1'b0, 4'd4));
    tbl.push_back(mk(6'b010001, S_MEM,   P_NONE, 1'b0, 1'b0, 1'b0, 4'd4));
    tbl.push_back(mk(6'b000000, S_IDLE,  P_IFU,  1'b0, 1'b0, 1'b0, 4'd4));
    // Flush during WB still retires.
    tbl.push_back(mk(6'b000100, S_FETCH, P_IDU,  1'b0, 1'b0, 1'b0, 4'd4));
    tbl.push_back(mk(6'b000000, S_DEC,   P_EXU,  1'b0, 1'b0, 1'b0, 4'd4));
    tbl.push_back(mk(6'b000010, S_EXEC,  P_WB,   1'b0, 1'b0, 1'b0, 4'd4));
    tbl.push_back(mk(6'b010000, S_WB,    P_NONE, 1'b1, 1'b0, 1'b0, 4'd4));
    tbl.push_back(mk(6'b000000, S_IDLE,  P_IFU,  1'b0, 1'b0, 1'b0, 4'd5));
    // Run the count up to 15.
    for (int i = 5; i < 15; i++) begin
      tbl.push_back(mk(ALL, S_FETCH, P_IDU, 1'b0, 1'b0, 1'b0, 4'(i)));
      tbl.push_back(mk(ALL, S_DEC,   P_EXU, 1'b0, 1'b0, 1'b0, 4'(i)));
      tbl.push_back(mk(ALL, S_EXEC,  P_WB,  1'b0, 1'b0, 1'b0, 4'(i)));
      tbl.push_back(mk(ALL, S_WB,    P_IFU, 1'b1, 1'b0, 1'b0, 4'(i)));
    end
    // Halt across WB, counter wraps 15 -> 0, restart on halt release.
    tbl.push_back(mk(6'b000100, S_FETCH, P_IDU,  1'b0, 1'b0, 1'b0, 4'd15));
    tbl.push_back(mk(6'b000000, S_DEC,   P_EXU,  1'b0, 1'b0, 1'b0, 4'd15));
    tbl.push_back(mk(6'b100010, S_EXEC,  P_WB,   1'b0, 1'b0, 1'b0, 4'd15));
    tbl.push_back(mk(6'b100000, S_WB,    P_NONE, 1'b1, 1'b0, 1'b0, 4'd15));
    tbl.push_back(mk(6'b100000, S_IDLE,  P_NONE, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl.push_back(mk(6'b100000, S_IDLE,  P_NONE, 1'b0, 1'b1, 1'b0, 4'd0));
    tbl.push_back(mk(6'b000000, S_IDLE,  P_IFU,  1'b0, 1'b0, 1'b0, 4'd0));
    // Foreign finishes ignored in FETCH and EXEC.
    tbl.push_back(mk(6'b000011, S_FETCH, P_NONE, 1'b0, 1'b0, 1'b0, 4'd0));
    tbl.push_back(mk(6'b000100, S_FETCH, P_IDU,  1'b0, 1'b0, 1'b0, 4'd0));
    tbl.push_back(mk(6'b000000, S_DEC,   P_EXU,  1'b0, 1'b0, 1'b0, 4'd0));
    // exu_finish in the 8th (last allowed) EXEC cycle wins over timeout.
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(6'b000101, S_EXEC, P_NONE, 1'b0, 1'b0, 1'b0, 4'd0));
    tbl.push_back(mk(6'b000010, S_EXEC,  P_WB,   1'b0, 1'b0, 1'b0, 4'd0));
    tbl.push_back(mk(6'b000000, S_WB,    P_IFU,  1'b1, 1'b0, 1'b0, 4'd0));
    tbl.push_back(mk(6'b000100, S_FETCH, P_IDU,  1'b0, 1'b0, 1'b0, 4'd1));
    tbl.push_back(mk(6'b000000, S_DEC,   P_EXU,  1'b0, 1'b0, 1'b0, 4'd1));
    // exu_finish never comes: 8 EXEC cycles then sticky FAULT.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(6'b000000, S_EXEC, P_NONE, 1'b0, 1'b0, 1'b0, 4'd1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(6'b001111, S_FAULT, P_NONE, 1'b0, 1'b0, 1'b1, 4'd1));
    tbl.push_back(mk(6'b110111, S_FAULT, P_NONE, 1'b0, 1'b0, 1'b1, 4'd1));

    // Reset state: pulses forced low even though IDLE with halt_req=0.
    rst = 1'b0;
    {halt_req, flush, need_mem, ifu_finish, exu_finish, memu_finish} = '0;
    repeat (2) @(negedge clk);
    chk("reset_stage", 16'(stage), 16'(S_IDLE));
    chk("reset_pulses", 16'({ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid}), 16'(P_NONE));
    chk("reset_retire", 16'(retire), 16'd0);
    chk("reset_timeout_err", 16'(timeout_err), 16'd0);
    chk("reset_retire_cnt", 16'(retire_cnt), 16'd0);

    @(posedge clk);
    #1 rst = 1'b1;
    apply(tbl[0], 0);
    for (int i = 1; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      apply(tbl[i], i);
    end

    // Reset out of FAULT clears everything immediately, then restarts.
    @(posedge clk);
    #1;
    {halt_req, flush, need_mem, ifu_finish, exu_finish, memu_finish} = '0;
    rst = 1'b0;
    #1;
    chk("midrst_stage", 16'(stage), 16'(S_IDLE));
    chk("midrst_timeout_err", 16'(timeout_err), 16'd0);
    chk("midrst_retire_cnt", 16'(retire_cnt), 16'd0);
    chk("midrst_pulses", 16'({ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid}), 16'(P_NONE));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_ifu_valid", 16'(ifu_valid), 16'd1);
    @(posedge clk);
    #1;
    chk("release_stage", 16'(stage), 16'(S_FETCH));
    chk("release_pulses", 16'({ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid}), 16'(P_NONE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
